seq_decode: RTL and testbench
=============================

Name: seq_decode

Overview:
Decode/register-file stage of the sequential (SEQ) Y86-64 processor. It derives source and destination register IDs from icode/rA/rB. It reads valA/valB combinationally from a 15-entry x 64-bit register file and performs write-back of valE/valM on the rising clock edge. It sits between fetch (icode, rA, rB) and execute (valA, valB), and receives write-back data from the execute and memory stages.

Parameters:
- WIDTH, 64, register/data width in bits.
- NREG, 15, number of architectural registers (IDs 0..14); ID 15 (0xF) = RNONE.

Ports:
- clk  input  1  system clock; all register writes occur on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- icode  input  4  instruction code from fetch.
- rA  input  4  register A field.
- rB  input  4  register B field.
- cnd  input  1  condition flag from execute; gates the rrmovq/cmovXX write.
- valE  input  64  execute result for write-back.
- valM  input  64  memory result for write-back.
- srcA  output  4  decoded source-A register ID.
- srcB  output  4  decoded source-B register ID.
- dstE  output  4  decoded E-destination register ID.
- dstM  output  4  decoded M-destination register ID.
- valA  output  64  R[srcA], or 0 when srcA = 0xF.
- valB  output  64  R[srcB], or 0 when srcB = 0xF.

Behaviour:
- Register ID 4 is RSP.
- srcA:
  - rA for icode 2 (rrmovq/cmov), 4 (rmmovq), 6 (OPq), 0xA (pushq).
  - RSP for 0xB (popq), 9 (ret).
  - 0xF otherwise.
- srcB:
  - rB for icode 4, 5 (mrmovq), 6.
  - RSP for 0xA, 0xB, 8 (call), 9.
  - 0xF otherwise.
- dstE:
  - rB for icode 2 when cnd = 1; 0xF when cnd = 0.
  - rB for icode 3 (irmovq) and 6.
  - RSP for 0xA, 0xB, 8, 9.
  - 0xF otherwise.
- dstM: rA for icode 5 and 0xB; 0xF otherwise.
- icodes 0, 1, 7, 0xC..0xF (halt, nop, jXX, invalid): all four IDs are 0xF, valA = valB = 0.
- rA/rB fields are used as given, even when they equal 0xF; reading ID 0xF returns 0.
- Reads are fully combinational; zero-cycle latency from icode/rA/rB to valA/valB.
- Write-back on rising clk:
  - if dstE != 0xF, R[dstE] <= valE;
  - if dstM != 0xF, R[dstM] <= valM;
  - if dstE == dstM (e.g. popq %rsp), valM wins.
- Writes to ID 0xF are discarded.
- Without bypass, a read of a register written this cycle returns the old value until after the edge.
- Reset:
  - When rst_n = 0, asynchronously set R[i] = i for i = 0..14 (deterministic, distinguishable contents).
  - Writes are blocked while rst_n = 0; deassertion takes effect at the next edge.
  - Reset asserted mid-operation overrides any pending write on that edge.
  - Outputs after reset: the ID outputs follow the inputs combinationally; valA/valB reflect the reset contents.
- No X propagation: all outputs are defined for every input combination.

Optional Feature:
- Macro: DECODE_WB_BYPASS_EN.
- Defined: write-through bypass. If srcA (or srcB) equals a non-0xF dstM, valA (valB) = valM. Otherwise, if it equals a non-0xF dstE, valA (valB) = valE. Otherwise the value is read from the register file. The priority valM > valE matches the write rule.
- Undefined: pure register-file read; no bypass logic is generated.

Test Plan:
- Reset, then icode=2 rA=2 rB=2 cnd=1 -> srcA=2, srcB=F, valA=2, valB=0, dstE=2, dstM=F.
- icode=4 rA=0xC rB=5 -> valA=12, valB=5, dstE=F. Then icode=5 rA=0xE rB=9 -> srcA=F, valA=0, valB=9, dstM=0xE.
- icode=8 (call), icode=9 (ret), icode=0xA rA=5, icode=0xB rA=0 -> check RSP usage:
  - call: valB=4, dstE=4.
  - ret: valA=4, valB=4.
  - pushq: valA=5, valB=4.
  - popq: dstE=4, dstM=0.
- Write: icode=3 rB=3 valE=0x1234, one rising edge -> R3 = 0x1234; next cycle icode=6 rA=3 rB=3 -> valA=valB=0x1234. Then icode=2 rB=7 cnd=0 valE=0xAA, edge -> R7 stays 7.
- Conflict: icode=0xB rA=4 valE=0x100 valM=0x200, edge -> R4 = 0x200.
- Reset mid-run: write R1=0xDEAD, assert rst_n=0 between edges -> R1 reads 1 immediately. With DECODE_WB_BYPASS_EN: icode=0xB rA=4 valM=0x77 -> valA=0x77 before the edge.

Source files
------------

// File: rtl/seq_decode.sv
// SEQ Y86-64 decode / write-back stage: register ID decode plus a 15 x 64-bit register file.
// Optional write-through bypass of valM/valE onto valA/valB when DECODE_WB_BYPASS_EN is defined.
module seq_decode #(
    parameter int WIDTH = 64,
    parameter int NREG  = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       icode,
    input  logic [3:0]       rA,
    input  logic [3:0]       rB,
    input  logic             cnd,
    input  logic [WIDTH-1:0] valE,
    input  logic [WIDTH-1:0] valM,
    output logic [3:0]       srcA,
    output logic [3:0]       srcB,
    output logic [3:0]       dstE,
    output logic [3:0]       dstM,
    output logic [WIDTH-1:0] valA,
    output logic [WIDTH-1:0] valB
);

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RSP   = 4'h4;

    typedef enum logic [3:0] {
        I_HALT   = 4'h0,
        I_NOP    = 4'h1,
        I_RRMOVQ = 4'h2,
        I_IRMOVQ = 4'h3,
        I_RMMOVQ = 4'h4,
        I_MRMOVQ = 4'h5,
        I_OPQ    = 4'h6,
        I_JXX    = 4'h7,
        I_CALL   = 4'h8,
        I_RET    = 4'h9,
        I_PUSHQ  = 4'hA,
        I_POPQ   = 4'hB
    } icode_e;

    logic [WIDTH-1:0] regFile [NREG];
    logic [WIDTH-1:0] rfA;
    logic [WIDTH-1:0] rfB;

    always_comb begin
        srcA = RNONE;
        srcB = RNONE;
        dstE = RNONE;
        dstM = RNONE;
        case (icode)
            I_RRMOVQ: begin
                srcA = rA;
                dstE = cnd ? rB : RNONE;
            end
            I_IRMOVQ: dstE = rB;
            I_RMMOVQ: begin
                srcA = rA;
                srcB = rB;
            end
            I_MRMOVQ: begin
                srcB = rB;
                dstM = rA;
            end
            I_OPQ: begin
                srcA = rA;
                srcB = rB;
                dstE = rB;
            end
            I_CALL: begin
                srcB = RSP;
                dstE = RSP;
            end
            I_RET: begin
                srcA = RSP;
                srcB = RSP;
                dstE = RSP;
            end
            I_PUSHQ: begin
                srcA = rA;
                srcB = RSP;
                dstE = RSP;
            end
            I_POPQ: begin
                srcA = RSP;
                srcB = RSP;
                dstE = RSP;
                dstM = rA;
            end
            default: ;
        endcase
    end

    // Reset loads R[i] = i; on a dstE/dstM collision the later valM assignment wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regFile[i] <= WIDTH'(i);
            end
        end else begin
            if (dstE != RNONE) begin
                regFile[dstE] <= valE;
            end
            if (dstM != RNONE) begin
                regFile[dstM] <= valM;
            end
        end
    end

    assign rfA = (srcA == RNONE) ? '0 : regFile[srcA];
    assign rfB = (srcB == RNONE) ? '0 : regFile[srcB];

`ifdef DECODE_WB_BYPASS_EN
    // A matching srcX can only equal a dst that is itself not RNONE, so one guard suffices.
    always_comb begin
        valA = rfA;
        valB = rfB;
        if (srcA != RNONE && srcA == dstM) begin
            valA = valM;
        end else if (srcA != RNONE && srcA == dstE) begin
            valA = valE;
        end
        if (srcB != RNONE && srcB == dstM) begin
            valB = valM;
        end else if (srcB != RNONE && srcB == dstE) begin
            valB = valE;
        end
    end
`else
    assign valA = rfA;
    assign valB = rfB;
`endif

endmodule

// File: tb/tb_seq_decode.sv
// Self-checking bench for seq_decode: directed literal checks plus randomized traffic
// compared every cycle against an architectural register-file model (honours DECODE_WB_BYPASS_EN).
module tb_seq_decode;

    logic        clk;
    logic        rst_n;
    logic [3:0]  icode;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic        cnd;
    logic [63:0] valE;
    logic [63:0] valM;
    logic [3:0]  srcA;
    logic [3:0]  srcB;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
    logic [63:0] valA;
    logic [63:0] valB;

    int errors = 0;
    int checks = 0;

    logic [63:0] model [15];
    logic [3:0]  wbE;
    logic [3:0]  wbM;
    logic [63:0] bypExp;

    seq_decode dut (
        .clk   (clk),
        .rst_n (rst_n),
        .icode (icode),
        .rA    (rA),
        .rB    (rB),
        .cnd   (cnd),
        .valE  (valE),
        .valM  (valM),
        .srcA  (srcA),
        .srcB  (srcB),
        .dstE  (dstE),
        .dstM  (dstM),
        .valA  (valA),
        .valB  (valB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register-ID tables written straight from the instruction semantics.
    function automatic logic [3:0] mSrcA(input logic [3:0] ic, input logic [3:0] a);
        case (ic)
            4'h2, 4'h4, 4'h6, 4'hA: return a;
            4'h9, 4'hB:             return 4'h4;
            default:                return 4'hF;
        endcase
    endfunction

    function automatic logic [3:0] mSrcB(input logic [3:0] ic, input logic [3:0] b);
        case (ic)
            4'h4, 4'h5, 4'h6:       return b;
            4'h8, 4'h9, 4'hA, 4'hB: return 4'h4;
            default:                return 4'hF;
        endcase
    endfunction

    function automatic logic [3:0] mDstE(input logic [3:0] ic, input logic [3:0] b, input logic c);
        case (ic)
            4'h2:                   return c ? b : 4'hF;
            4'h3, 4'h6:             return b;
            4'h8, 4'h9, 4'hA, 4'hB: return 4'h4;
            default:                return 4'hF;
        endcase
    endfunction

    function automatic logic [3:0] mDstM(input logic [3:0] ic, input logic [3:0] a);
        return (ic == 4'h5 || ic == 4'hB) ? a : 4'hF;
    endfunction

    function automatic logic [63:0] mRead(input logic [3:0] src);
        logic [3:0] e;
        logic [3:0] m;
        e = mDstE(icode, rB, cnd);
        m = mDstM(icode, rA);
        if (src == 4'hF) return 64'd0;
`ifdef DECODE_WB_BYPASS_EN
        if (src == m) return valM;
        if (src == e) return valE;
`endif
        return model[src];
    endfunction

    // Architectural state: reset image, then per-edge write-back with valM applied last.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 15; i++) model[i] = 64'(i);
        end else begin
            wbE = mDstE(icode, rB, cnd);
            wbM = mDstM(icode, rA);
            if (wbE != 4'hF) model[wbE] = valE;
            if (wbM != 4'hF) model[wbM] = valM;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic checkModel();
        checkOutput("srcA", 64'(srcA), 64'(mSrcA(icode, rA)));
        checkOutput("srcB", 64'(srcB), 64'(mSrcB(icode, rB)));
        checkOutput("dstE", 64'(dstE), 64'(mDstE(icode, rB, cnd)));
        checkOutput("dstM", 64'(dstM), 64'(mDstM(icode, rA)));
        checkOutput("valA", valA, mRead(mSrcA(icode, rA)));
        checkOutput("valB", valB, mRead(mSrcB(icode, rB)));
    endtask

    task automatic applyStimulus(input logic [3:0] ic, input logic [3:0] a, input logic [3:0] b,
                                 input logic c, input logic [63:0] e, input logic [63:0] m);
        icode = ic;
        rA    = a;
        rB    = b;
        cnd   = c;
        valE  = e;
        valM  = m;
        #1;
    endtask

    // Compare against the model at the falling edge, then return just after the next rising edge.
    task automatic nextCycle();
        @(negedge clk);
        checkModel();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(4'h1, 4'h0, 4'h0, 1'b0, 64'd0, 64'd0);
        nextCycle();

        for (int i = 0; i < 15; i++) begin
            applyStimulus(4'h6, 4'(i), 4'(14 - i), 1'b1, 64'hFFFF, 64'hFFFF);
            checkOutput("reset_R_a", valA, 64'(i));
            nextCycle();
        end
        rst_n = 1'b1;

        applyStimulus(4'h2, 4'h2, 4'h2, 1'b1, 64'h2, 64'h0);
        checkOutput("rrmov_srcA", 64'(srcA), 64'h2);
        checkOutput("rrmov_srcB", 64'(srcB), 64'hF);
        checkOutput("rrmov_valA", valA, 64'h2);
        checkOutput("rrmov_valB", valB, 64'h0);
        checkOutput("rrmov_dstE", 64'(dstE), 64'h2);
        checkOutput("rrmov_dstM", 64'(dstM), 64'hF);
        nextCycle();

        applyStimulus(4'h4, 4'hC, 4'h5, 1'b0, 64'h0, 64'h0);
        checkOutput("rmmov_valA", valA, 64'd12);
        checkOutput("rmmov_valB", valB, 64'd5);
        checkOutput("rmmov_dstE", 64'(dstE), 64'hF);
        nextCycle();

        applyStimulus(4'h5, 4'hE, 4'h9, 1'b0, 64'h0, 64'hE);
        checkOutput("mrmov_srcA", 64'(srcA), 64'hF);
        checkOutput("mrmov_valA", valA, 64'h0);
        checkOutput("mrmov_valB", valB, 64'd9);
        checkOutput("mrmov_dstM", 64'(dstM), 64'hE);
        nextCycle();

        applyStimulus(4'h8, 4'h0, 4'h0, 1'b0, 64'h4, 64'h0);
        checkOutput("call_valB", valB, 64'h4);
        checkOutput("call_dstE", 64'(dstE), 64'h4);
        nextCycle();
        applyStimulus(4'h9, 4'h0, 4'h0, 1'b0, 64'h4, 64'h0);
        checkOutput("ret_valA", valA, 64'h4);
        checkOutput("ret_valB", valB, 64'h4);
        nextCycle();
        applyStimulus(4'hA, 4'h5, 4'hF, 1'b0, 64'h4, 64'h0);
        checkOutput("push_valA", valA, 64'h5);
        checkOutput("push_valB", valB, 64'h4);
        nextCycle();
        applyStimulus(4'hB, 4'h0, 4'hF, 1'b0, 64'h4, 64'h0);
        checkOutput("pop_dstE", 64'(dstE), 64'h4);
        checkOutput("pop_dstM", 64'(dstM), 64'h0);
        nextCycle();

        applyStimulus(4'h3, 4'hF, 4'h3, 1'b0, 64'h1234, 64'h0);
        nextCycle();
        applyStimulus(4'h6, 4'h3, 4'h3, 1'b0, 64'h1234, 64'h0);
        checkOutput("opq_valA", valA, 64'h1234);
        checkOutput("opq_valB", valB, 64'h1234);
        nextCycle();

        applyStimulus(4'h2, 4'h1, 4'h7, 1'b0, 64'hAA, 64'h0);
        checkOutput("cmov_nc_dstE", 64'(dstE), 64'hF);
        nextCycle();
        applyStimulus(4'h4, 4'h7, 4'hF, 1'b0, 64'h0, 64'h0);
        checkOutput("cmov_nc_R7", valA, 64'h7);
        nextCycle();

        applyStimulus(4'hB, 4'h4, 4'hF, 1'b0, 64'h100, 64'h200);
        nextCycle();
        applyStimulus(4'h4, 4'h4, 4'hF, 1'b0, 64'h0, 64'h0);
        checkOutput("pop_rsp_R4", valA, 64'h200);
        nextCycle();

        applyStimulus(4'h3, 4'hF, 4'h1, 1'b0, 64'hDEAD, 64'h0);
        nextCycle();
        applyStimulus(4'h4, 4'h1, 4'hF, 1'b0, 64'h0, 64'h0);
        checkOutput("wr_R1", valA, 64'hDEAD);
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_R1", valA, 64'h1);
        applyStimulus(4'h3, 4'hF, 4'h1, 1'b0, 64'hBEEF, 64'h0);
        nextCycle();
        applyStimulus(4'h4, 4'h1, 4'hF, 1'b0, 64'h0, 64'h0);
        checkOutput("rst_blocks_wr", valA, 64'h1);
        rst_n = 1'b1;

`ifdef DECODE_WB_BYPASS_EN
        bypExp = 64'h77;
`else
        bypExp = 64'h4;
`endif
        applyStimulus(4'hB, 4'h4, 4'hF, 1'b0, 64'h55, 64'h77);
        checkOutput("bypass_valA", valA, bypExp);
        checkOutput("bypass_valB", valB, bypExp);
        nextCycle();

        for (int n = 0; n < 600; n++) begin
            rst_n = ($urandom_range(0, 59) == 0) ? 1'b0 : 1'b1;
            applyStimulus(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                          4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                          {$urandom, $urandom}, {$urandom, $urandom});
            nextCycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
